// File: rtl/alu16_seq_ctrl_if.sv
// Request/response bundle for the nibble-serial ALU controller.
// The master side presents operations and consumes results; the slave side is the ALU.
interface alu16_seq_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, busy
  );
endinterface

// File: rtl/alu16_seq_ctrl.sv
// Nibble-serial ALU: one W-bit operation runs LSB nibble first through a single
// 4-bit slice, with an IDLE/EXEC/DONE valid-ready handshake around it.
module alu16_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  alu16_seq_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   result_q;
  logic [CW-1:0]  cnt;
  logic           carry_q;
  logic           zacc;
  logic           cout_q;
  logic           ovf_q;
  logic           zero_q;

  logic           last;
  logic [CW+1:0]  base;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     b_eff;
  logic [3:0]     nib_res;
  logic [4:0]     sum5;
  logic           c_into_msb;
  logic           nib_ovf;
  logic           arith;
  logic           is_slt;
  logic           slt_bit;

  assign last = (cnt == CW'(NIBBLES - 1));

  // Single 4-bit slice; op[2] both inverts b and seeds the carry on accept.
  always_comb begin
    base       = {cnt, 2'b00};
    a_nib      = a_q[base +: 4];
    b_nib      = b_q[base +: 4];
    b_eff      = op_q[2] ? ~b_nib : b_nib;
    sum5       = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry_q};
    c_into_msb = a_nib[3] ^ b_eff[3] ^ sum5[3];
    nib_ovf    = c_into_msb ^ sum5[4];
    arith      = op_q[1] && (op_q != 3'b011);
    is_slt     = (op_q == 3'b111);
    slt_bit    = sum5[3] ^ nib_ovf;
    case (op_q[1:0])
      2'b00:   nib_res = a_nib & b_eff;
      2'b01:   nib_res = a_nib | b_eff;
      2'b10:   nib_res = sum5[3:0];
      default: nib_res = op_q[2] ? sum5[3:0] : 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = EXEC;
      EXEC:    if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      carry_q  <= 1'b0;
      zacc     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            cnt     <= '0;
            carry_q <= bus.op[2];
            zacc    <= 1'b0;
          end
        end
        EXEC: begin
          cnt                <= cnt + CW'(1);
          carry_q            <= sum5[4];
          zacc               <= zacc | (|nib_res);
          result_q[base +: 4] <= nib_res;
          if (last) begin
            cout_q <= arith & sum5[4];
            ovf_q  <= arith & nib_ovf;
            // SLT replaces the accumulated difference with the sign-corrected compare bit.
            if (is_slt) begin
              result_q <= {{(W-1){1'b0}}, slt_bit};
              zero_q   <= ~slt_bit;
            end else begin
              zero_q   <= ~(zacc | (|nib_res));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// Directed and randomized checks of alu16_seq_ctrl against a whole-word arithmetic model.
module tb_alu16_seq_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu16_seq_ctrl_if #(.W(16)) bus ();

  alu16_seq_ctrl #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  // Whole-word reference: 17-bit sums, signed compare, sign-rule overflow.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    e = '0;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b100: e.result = a & ~b;
      3'b101: e.result = a | ~b;
      3'b010: begin
        s        = {1'b0, a} + {1'b0, b};
        e.result = s[15:0];
        e.cout   = s[16];
        e.ovf    = (a[15] == b[15]) && (s[15] != a[15]);
      end
      3'b110, 3'b111: begin
        s        = {1'b0, a} + {1'b0, ~b} + 17'd1;
        e.cout   = s[16];
        e.ovf    = (a[15] != b[15]) && (s[15] != a[15]);
        if (op == 3'b110) e.result = s[15:0];
        else              e.result = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      end
      default: e.result = 16'h0000;
    endcase
    e.zero = (e.result == 16'h0000);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, four slice edges, optional DONE backpressure, handshake.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit noisy);
    exp_t e;
    e = model(op, a, b);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    check("in_ready_before_accept", bus.in_ready, 1);
    tick();
    if (noisy) begin
      bus.op = 3'($urandom_range(0, 7));
      bus.a  = 16'($urandom);
      bus.b  = 16'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      check("exec_out_valid", bus.out_valid, 0);
      check("exec_busy", bus.busy, 1);
      check("exec_in_ready", bus.in_ready, 0);
      tick();
    end
    check("done_out_valid", bus.out_valid, 1);
    check("result", bus.result, e.result);
    check("cout", bus.cout, e.cout);
    check("overflow", bus.overflow, e.ovf);
    check("zero", bus.zero, e.zero);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_result", bus.result, e.result);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("post_hs_out_valid", bus.out_valid, 0);
    check("post_hs_in_ready", bus.in_ready, 1);
    check("post_hs_busy", bus.busy, 0);
  endtask

  task automatic check_reset_state(input string where);
    check({where, "_in_ready"}, bus.in_ready, 1);
    check({where, "_busy"}, bus.busy, 0);
    check({where, "_out_valid"}, bus.out_valid, 0);
    check({where, "_result"}, bus.result, 0);
    check({where, "_flags"}, {bus.cout, bus.overflow, bus.zero}, 0);
  endtask

  logic [15:0] edge_vals [6];

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    do_op(3'b010, 16'h7FFF, 16'h0001, 0, 0);
    do_op(3'b010, 16'hFFFF, 16'h0001, 0, 0);
    do_op(3'b110, 16'h8000, 16'h0001, 0, 0);
    do_op(3'b110, 16'h0005, 16'h0005, 0, 0);
    do_op(3'b111, 16'h8000, 16'h0001, 0, 0);
    do_op(3'b111, 16'h0001, 16'h8000, 0, 0);
    do_op(3'b111, 16'hFFFF, 16'h0000, 0, 0);
    do_op(3'b011, 16'hABCD, 16'h1234, 0, 0);
    do_op(3'b000, 16'hF0F0, 16'h3C3C, 0, 0);
    do_op(3'b101, 16'h0000, 16'hFFFF, 0, 0);

    // Backpressure with a new request held on in_valid; it may only land after the handshake.
    do_op(3'b010, 16'h1234, 16'h4321, 3, 1);
    do_op(3'b110, 16'h0010, 16'h0020, 0, 0);

    // Reset in the middle of EXEC (slice 2 in flight).
    bus.in_valid = 1'b1;
    bus.op       = 3'b010;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_exec");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_exec_no_pulse", bus.out_valid, 0);
    end
    do_op(3'b010, 16'h0003, 16'h0004, 0, 0);

    // Reset while a result waits in DONE.
    bus.in_valid = 1'b1;
    bus.op       = 3'b001;
    bus.a        = 16'h00F0;
    bus.b        = 16'h000F;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_done", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    check_reset_state("rst_done");

    // Reset wins over a simultaneous accept.
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_vs_accept_busy", bus.busy, 0);

    edge_vals[0] = 16'h0000;
    edge_vals[1] = 16'hFFFF;
    edge_vals[2] = 16'h8000;
    edge_vals[3] = 16'h7FFF;
    edge_vals[4] = 16'h0001;
    edge_vals[5] = 16'h000F;
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  r_op;
      logic [15:0] r_a;
      logic [15:0] r_b;
      r_op = 3'($urandom_range(0, 7));
      r_a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom);
      r_b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom);
      do_op(r_op, r_a, r_b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu16_seq_ctrl.md
ALU16_SEQ_CTRL -- requirements
Module: alu16_seq_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4; number of 4-bit slices per operation, so operand width is 4*NIBBLES.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 op  input  3  ALU op; encoding identical to team 4-bit ALU: op[2] = invert-b and carry-in.
REQ-007 a, b  input  16  operands; sampled only on accept.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 result  output  16  operation result.
REQ-011 cout, overflow, zero  output  1 each  carry-out of MSB slice, signed overflow, result==0.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Block SHALL execute one 16-bit op as 4 sequential nibble slices, LSB nibble first, through a single 4-bit ALU datapath.
REQ-014 States SHALL be IDLE, EXEC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept = in_valid && in_ready at an edge; op, a, b SHALL be registered, slice counter set to 0, carry register set to op[2], state -> EXEC.
REQ-016 In EXEC, each cycle SHALL process nibble[counter]; at the edge, result nibble, carry and zero-accumulator are stored and the counter increments.
REQ-017 At the edge completing nibble 3, state SHALL go EXEC -> DONE; out_valid is first high 4 edges after the accept edge.
REQ-018 In DONE, result/flags SHALL hold stable until out_valid && out_ready at an edge, then state -> IDLE; no new accept in the same edge.
REQ-019 Changes to in_valid, op, a, b during EXEC/DONE SHALL be ignored.
REQ-020 Op semantics per nibble: 000 a&b; 001 a|b; 100 a&~b; 101 a|~b; 010 a+b+c; 110 a+~b+c (SUB, initial c=1).
REQ-021 Op 111 (SLT) SHALL compute a-b across all slices; result = 16'h0001 if signed a<b (MSB of difference XOR overflow), else 16'h0000.
REQ-022 Op 011 SHALL produce result 0, cout 0, overflow 0, zero 1.
REQ-023 cout = carry out of nibble 3 for 010/110/111; 0 for logic ops.
REQ-024 overflow = carry into bit 15 XOR carry out of bit 15 for 010/110/111; 0 for logic ops.
REQ-025 zero SHALL reflect the final 16-bit result value.
REQ-026 No arithmetic wraps beyond 16 bits; carry out of bit 15 appears only on cout.

Reset
REQ-027 On rst at an edge: state IDLE, counter 0, carry 0, result 0, cout 0, overflow 0, zero 0, out_valid 0, busy 0, in_ready 1 after that edge.
REQ-028 rst SHALL take priority over accept, slice advance and out_ready; reset mid-EXEC or in DONE discards the operation with no out_valid pulse.

Verification
REQ-029 ADD a=16'h7FFF b=16'h0001 -> result 16'h8000, overflow 1, cout 0, zero 0; out_valid exactly 4 edges after accept.
REQ-030 ADD a=16'hFFFF b=16'h0001 -> result 16'h0000, cout 1, overflow 0, zero 1.
REQ-031 SUB a=16'h8000 b=16'h0001 -> result 16'h7FFF, overflow 1, cout 1; SUB 16'h0005-16'h0005 -> 0, zero 1, cout 1.
REQ-032 SLT a=16'h8000 b=16'h0001 -> 16'h0001; SLT a=16'h0001 b=16'h8000 -> 16'h0000; SLT 16'hFFFF vs 16'h0000 -> 16'h0001.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> result stable, in_ready 0, second op not accepted until cycle after handshake.
REQ-034 Assert rst during EXEC slice 2 -> next cycle in_ready 1, busy 0, out_valid 0; a subsequent ADD 16'h0003+16'h0004 returns 16'h0007.
